// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter and its write serializer.
package mem_bus_arbiter_pkg;

  localparam int LINE_WORDS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_WR_RESP = 3'd5
  } arb_state_t;

  typedef enum logic {
    OWN_ICACHE = 1'b0,
    OWN_DCACHE = 1'b1
  } arb_owner_t;

  // Bus burst length field (beats minus one): single beat for uncached, full line otherwise.
  function automatic logic [7:0] burst_len(input logic uncached, input int line_words);
    return uncached ? 8'd0 : 8'(line_words - 1);
  endfunction

endpackage

// File: rtl/mem_arb_wr_serializer.sv
// Captures a dcache write (line or single word) at grant and presents it one beat at a time.
module mem_arb_wr_serializer
  import mem_bus_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    advance,
  input  logic [32*LINE_WORDS-1:0] line_in,
  input  logic [3:0]              strb_in,
  input  logic                    uncached_in,
  output logic [31:0]             wdata,
  output logic                    wlast,
  output logic [3:0]              wstrb
);

  localparam int BEAT_W = $clog2(LINE_WORDS);

  logic [32*LINE_WORDS-1:0] line_q, line_d;
  logic [3:0]               strb_q, strb_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [BEAT_W-1:0]        last_q, last_d;
  logic [31:0]              words [LINE_WORDS];

  // Split the latched line into addressable words (word 0 in the low bits).
  generate
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      assign words[gi] = line_q[gi*32 +: 32];
    end
  endgenerate

  // Latch on grant; step the beat pointer on each accepted data beat.
  always_comb begin
    line_d = line_q;
    strb_d = strb_q;
    beat_d = beat_q;
    last_d = last_q;
    if (load) begin
      line_d = line_in;
      strb_d = uncached_in ? strb_in : 4'hF;
      beat_d = '0;
      last_d = uncached_in ? '0 : BEAT_W'(LINE_WORDS - 1);
    end else if (advance) begin
      beat_d = beat_q + 1'b1;
    end
  end

  // Serializer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      strb_q <= '0;
      beat_q <= '0;
      last_q <= '0;
    end else begin
      line_q <= line_d;
      strb_q <= strb_d;
      beat_q <= beat_d;
      last_q <= last_d;
    end
  end

  assign wdata = words[beat_q];
  assign wlast = (beat_q == last_q);
  assign wstrb = strb_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the icache and dcache onto one SRAM-like bus and sequences each transaction.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     icache_rd_req,
  input  logic [ADDR_W-1:0]        icache_rd_addr,
  output logic                     icache_rd_ack,
  output logic                     icache_ret_valid,
  output logic                     icache_ret_last,
  output logic [31:0]              icache_ret_data,
  input  logic                     dcache_rd_req,
  input  logic [ADDR_W-1:0]        dcache_rd_addr,
  input  logic                     dcache_rd_uncached,
  output logic                     dcache_rd_ack,
  output logic                     dcache_ret_valid,
  output logic                     dcache_ret_last,
  output logic [31:0]              dcache_ret_data,
  input  logic                     dcache_wr_req,
  input  logic [ADDR_W-1:0]        dcache_wr_addr,
  input  logic                     dcache_wr_uncached,
  input  logic [3:0]               dcache_wr_strb,
  input  logic [32*LINE_WORDS-1:0] dcache_wr_data,
  output logic                     dcache_wr_ack,
  output logic                     dcache_wr_done,
  output logic                     bus_req,
  output logic                     bus_wr,
  output logic [7:0]               bus_len,
  output logic [ADDR_W-1:0]        bus_addr,
  output logic [3:0]               bus_wstrb,
  input  logic                     bus_addr_ok,
  input  logic                     bus_rvalid,
  input  logic                     bus_rlast,
  input  logic [31:0]              bus_rdata,
  output logic                     bus_wvalid,
  output logic                     bus_wlast,
  output logic [31:0]              bus_wdata,
  input  logic                     bus_wready,
  input  logic                     bus_bvalid
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  arb_owner_t        last_rd_q, last_rd_d;
  arb_owner_t        pick;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic              wr_done_q, wr_done_d;
  logic              wr_load;
  logic [31:0]       ser_wdata;
  logic              ser_wlast;
  logic [3:0]        ser_wstrb;

  mem_arb_wr_serializer #(.LINE_WORDS(LINE_WORDS)) u_wr_ser (
    .clk         (clk),
    .rst         (rst),
    .load        (wr_load),
    .advance     (state_q == ST_WR_DATA && bus_wready),
    .line_in     (dcache_wr_data),
    .strb_in     (dcache_wr_strb),
    .uncached_in (dcache_wr_uncached),
    .wdata       (ser_wdata),
    .wlast       (ser_wlast),
    .wstrb       (ser_wstrb)
  );

  // Next state: write first, then round-robin between the two read requesters.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_rd_d = last_rd_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wr_load   = 1'b0;
    wr_done_d = 1'b0;
    pick      = OWN_DCACHE;
    case (state_q)
      ST_IDLE: begin
        if (dcache_wr_req) begin
          owner_d = OWN_DCACHE;
          addr_d  = dcache_wr_addr;
          len_d   = burst_len(dcache_wr_uncached, LINE_WORDS);
          wr_load = 1'b1;
          state_d = ST_WR_ADDR;
        end else if (icache_rd_req || dcache_rd_req) begin
          if (icache_rd_req && dcache_rd_req)
            pick = (last_rd_q == OWN_DCACHE) ? OWN_ICACHE : OWN_DCACHE;
          else
            pick = dcache_rd_req ? OWN_DCACHE : OWN_ICACHE;
          owner_d   = pick;
          last_rd_d = pick;
          if (pick == OWN_DCACHE) begin
            addr_d = dcache_rd_addr;
            len_d  = burst_len(dcache_rd_uncached, LINE_WORDS);
          end else begin
            addr_d = icache_rd_addr;
            len_d  = burst_len(1'b0, LINE_WORDS);
          end
          state_d = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: if (bus_addr_ok) state_d = ST_RD_DATA;
      ST_RD_DATA: if (bus_rvalid && bus_rlast) state_d = ST_IDLE;
      ST_WR_ADDR: if (bus_addr_ok) state_d = ST_WR_DATA;
      ST_WR_DATA: if (bus_wready && ser_wlast) state_d = ST_WR_RESP;
      ST_WR_RESP: begin
        if (bus_bvalid) begin
          wr_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, ownership and latched request registers; reset favours dcache for the first read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_DCACHE;
      last_rd_q <= OWN_ICACHE;
      addr_q    <= '0;
      len_q     <= '0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_rd_q <= last_rd_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wr_done_q <= wr_done_d;
    end
  end

  // Outputs per phase; everything is forced low while reset is asserted so a mid-burst reset drops beats and pulses at once.
  always_comb begin
    icache_rd_ack    = 1'b0;
    icache_ret_valid = 1'b0;
    icache_ret_last  = 1'b0;
    icache_ret_data  = '0;
    dcache_rd_ack    = 1'b0;
    dcache_ret_valid = 1'b0;
    dcache_ret_last  = 1'b0;
    dcache_ret_data  = '0;
    dcache_wr_ack    = 1'b0;
    dcache_wr_done   = 1'b0;
    bus_req          = 1'b0;
    bus_wr           = 1'b0;
    bus_len          = '0;
    bus_addr         = '0;
    bus_wstrb        = '0;
    bus_wvalid       = 1'b0;
    bus_wlast        = 1'b0;
    bus_wdata        = '0;
    if (!rst) begin
      dcache_wr_done = wr_done_q;
      case (state_q)
        ST_IDLE: dcache_wr_ack = dcache_wr_req;
        ST_RD_ADDR: begin
          bus_req  = 1'b1;
          bus_addr = addr_q;
          bus_len  = len_q;
          icache_rd_ack = bus_addr_ok && (owner_q == OWN_ICACHE);
          dcache_rd_ack = bus_addr_ok && (owner_q == OWN_DCACHE);
        end
        ST_RD_DATA: begin
          if (owner_q == OWN_ICACHE) begin
            icache_ret_valid = bus_rvalid;
            icache_ret_last  = bus_rvalid && bus_rlast;
            icache_ret_data  = bus_rdata;
          end else begin
            dcache_ret_valid = bus_rvalid;
            dcache_ret_last  = bus_rvalid && bus_rlast;
            dcache_ret_data  = bus_rdata;
          end
        end
        ST_WR_ADDR: begin
          bus_req   = 1'b1;
          bus_wr    = 1'b1;
          bus_addr  = addr_q;
          bus_len   = len_q;
          bus_wstrb = ser_wstrb;
        end
        ST_WR_DATA: begin
          bus_wvalid = 1'b1;
          bus_wlast  = ser_wlast;
          bus_wdata  = ser_wdata;
          bus_wstrb  = ser_wstrb;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: tests push expected events, a monitor pops and compares on every DUT output event.
module tb_mem_bus_arbiter;
  localparam int LW = 4;
  localparam int EV_ADDR = 1, EV_IACK = 2, EV_DACK = 3, EV_WACK = 4, EV_IRET = 5,
                 EV_DRET = 6, EV_WBEAT = 7, EV_WSTALL = 8, EV_WDONE = 9;

  typedef struct { int kind; logic [31:0] data; logic [31:0] aux; } ev_t;

  logic clk = 1'b0, rst;
  logic icache_rd_req, icache_rd_ack, icache_ret_valid, icache_ret_last;
  logic [31:0] icache_rd_addr, icache_ret_data;
  logic dcache_rd_req, dcache_rd_uncached, dcache_rd_ack, dcache_ret_valid, dcache_ret_last;
  logic [31:0] dcache_rd_addr, dcache_ret_data;
  logic dcache_wr_req, dcache_wr_uncached, dcache_wr_ack, dcache_wr_done;
  logic [31:0] dcache_wr_addr;
  logic [3:0] dcache_wr_strb;
  logic [32*LW-1:0] dcache_wr_data;
  logic bus_req, bus_wr, bus_addr_ok, bus_rvalid, bus_rlast, bus_wvalid, bus_wlast, bus_wready, bus_bvalid;
  logic [7:0] bus_len;
  logic [31:0] bus_addr, bus_rdata, bus_wdata;
  logic [3:0] bus_wstrb;

  ev_t exp_q[$];
  logic [31:0] rd_data_q[$];
  int checks = 0, errors = 0;
  int addr_delay = 0, stall_beat = -1, stall_cycles = 0, bresp_delay = 0;
  string cur_test = "reset";
  logic bv_prev = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .icache_rd_req(icache_rd_req), .icache_rd_addr(icache_rd_addr), .icache_rd_ack(icache_rd_ack),
    .icache_ret_valid(icache_ret_valid), .icache_ret_last(icache_ret_last), .icache_ret_data(icache_ret_data),
    .dcache_rd_req(dcache_rd_req), .dcache_rd_addr(dcache_rd_addr), .dcache_rd_uncached(dcache_rd_uncached),
    .dcache_rd_ack(dcache_rd_ack), .dcache_ret_valid(dcache_ret_valid), .dcache_ret_last(dcache_ret_last),
    .dcache_ret_data(dcache_ret_data),
    .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_uncached(dcache_wr_uncached),
    .dcache_wr_strb(dcache_wr_strb), .dcache_wr_data(dcache_wr_data), .dcache_wr_ack(dcache_wr_ack),
    .dcache_wr_done(dcache_wr_done),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_len(bus_len), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_addr_ok(bus_addr_ok), .bus_rvalid(bus_rvalid), .bus_rlast(bus_rlast), .bus_rdata(bus_rdata),
    .bus_wvalid(bus_wvalid), .bus_wlast(bus_wlast), .bus_wdata(bus_wdata), .bus_wready(bus_wready),
    .bus_bvalid(bus_bvalid)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] data, input logic [31:0] aux);
    ev_t e;
    e.kind = kind; e.data = data; e.aux = aux;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [31:0] data, input logic [31:0] aux);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event: got kind=%0d data=%h aux=%h, required no event", cur_test, kind, data, aux);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== data || e.aux !== aux) begin
        errors++;
        $display("FAIL %s event: got kind=%0d data=%h aux=%h, required kind=%0d data=%h aux=%h",
                 cur_test, kind, data, aux, e.kind, e.data, e.aux);
      end else begin
        $display("%s: event kind=%0d data=%h aux=%h ok", cur_test, kind, data, aux);
      end
    end
  endtask

  task automatic check_zero(input string name);
    logic [255:0] v;
    v = {icache_rd_ack, icache_ret_valid, icache_ret_last, icache_ret_data,
         dcache_rd_ack, dcache_ret_valid, dcache_ret_last, dcache_ret_data, dcache_wr_ack, dcache_wr_done,
         bus_req, bus_wr, bus_len, bus_addr, bus_wstrb, bus_wvalid, bus_wlast, bus_wdata};
    checks++;
    if (v != '0) begin
      errors++;
      $display("FAIL %s outputs: got %h, required all zero", name, v);
    end else begin
      $display("%s: all outputs zero ok", name);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin step(); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: got %0d events outstanding, required 0", cur_test, exp_q.size());
      exp_q.delete();
    end
    repeat (2) step();
  endtask

  task automatic icache_read(input logic [31:0] a);
    int n = 0;
    icache_rd_addr = a; icache_rd_req = 1'b1;
    forever begin
      @(negedge clk);
      if (icache_rd_ack) break;
      n++;
      if (n > 200) begin
        errors++; checks++;
        $display("FAIL %s icache_ack timeout: got no ack, required ack", cur_test);
        break;
      end
    end
    step();
    icache_rd_req = 1'b0; icache_rd_addr = '0;
  endtask

  task automatic dcache_read(input logic [31:0] a, input logic unc);
    int n = 0;
    dcache_rd_addr = a; dcache_rd_uncached = unc; dcache_rd_req = 1'b1;
    forever begin
      @(negedge clk);
      if (dcache_rd_ack) break;
      n++;
      if (n > 200) begin
        errors++; checks++;
        $display("FAIL %s dcache_rd_ack timeout: got no ack, required ack", cur_test);
        break;
      end
    end
    step();
    dcache_rd_req = 1'b0; dcache_rd_addr = '0; dcache_rd_uncached = 1'b0;
  endtask

  task automatic dcache_write(input logic [31:0] a, input logic unc, input logic [3:0] strb,
                              input logic [32*LW-1:0] line);
    int n = 0;
    dcache_wr_addr = a; dcache_wr_uncached = unc; dcache_wr_strb = strb; dcache_wr_data = line;
    dcache_wr_req = 1'b1;
    forever begin
      @(negedge clk);
      if (dcache_wr_ack) break;
      n++;
      if (n > 200) begin
        errors++; checks++;
        $display("FAIL %s dcache_wr_ack timeout: got no ack, required ack", cur_test);
        break;
      end
    end
    step();
    dcache_wr_req = 1'b0; dcache_wr_addr = '0; dcache_wr_data = '0; dcache_wr_strb = '0;
    dcache_wr_uncached = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check_zero("reset_state");
    step();
    rst = 1'b0;
  endtask

  // Monitor: one scoreboard comparison per DUT output event, in a fixed per-cycle order.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_req && bus_addr_ok) check_ev(EV_ADDR, bus_addr, {23'd0, bus_wr, bus_len});
        if (icache_rd_ack) check_ev(EV_IACK, 32'd0, 32'd0);
        if (dcache_rd_ack) check_ev(EV_DACK, 32'd0, 32'd0);
        if (dcache_wr_ack) check_ev(EV_WACK, 32'd0, 32'd0);
        if (icache_ret_valid) check_ev(EV_IRET, icache_ret_data, {31'd0, icache_ret_last});
        if (dcache_ret_valid) check_ev(EV_DRET, dcache_ret_data, {31'd0, dcache_ret_last});
        if (bus_wvalid) check_ev(bus_wready ? EV_WBEAT : EV_WSTALL, bus_wdata, {27'd0, bus_wstrb, bus_wlast});
        if (dcache_wr_done) check_ev(EV_WDONE, 32'd0, {31'd0, bv_prev});
      end
      bv_prev = bus_bvalid;
    end
  end

  // Bus slave model: address acceptance after addr_delay, read beats from rd_data_q, optional write stall.
  initial begin
    logic wr;
    logic [7:0] len;
    int beat, stalls;
    bus_addr_ok = 1'b0; bus_rvalid = 1'b0; bus_rlast = 1'b0; bus_rdata = '0;
    bus_wready = 1'b0; bus_bvalid = 1'b0;
    forever begin
      step();
      if (bus_req) begin
        repeat (addr_delay) step();
        bus_addr_ok = 1'b1; wr = bus_wr; len = bus_len;
        step();
        bus_addr_ok = 1'b0;
        if (!wr) begin
          for (int i = 0; i <= int'(len); i++) begin
            bus_rvalid = 1'b1;
            bus_rdata = (rd_data_q.size() != 0) ? rd_data_q.pop_front() : 32'hDEADBEEF;
            bus_rlast = (i == int'(len));
            step();
          end
          bus_rvalid = 1'b0; bus_rlast = 1'b0; bus_rdata = '0;
        end else begin
          beat = 0; stalls = stall_cycles;
          while (beat <= int'(len)) begin
            if (beat == stall_beat && stalls > 0) begin
              bus_wready = 1'b0; stalls--;
            end else begin
              bus_wready = 1'b1; beat++;
            end
            step();
          end
          bus_wready = 1'b0;
          repeat (bresp_delay) step();
          bus_bvalid = 1'b1;
          step();
          bus_bvalid = 1'b0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    icache_rd_req = 0; icache_rd_addr = 0;
    dcache_rd_req = 0; dcache_rd_addr = 0; dcache_rd_uncached = 0;
    dcache_wr_req = 0; dcache_wr_addr = 0; dcache_wr_uncached = 0; dcache_wr_strb = 0; dcache_wr_data = 0;
    #1;
    do_reset();

    // icache line refill, address accepted after two wait cycles
    cur_test = "icache_refill"; addr_delay = 2;
    for (int i = 0; i < 4; i++) rd_data_q.push_back(32'hA0 + i);
    expect_ev(EV_ADDR, 32'h1C000000, 32'h003);
    expect_ev(EV_IACK, 0, 0);
    for (int i = 0; i < 4; i++) expect_ev(EV_IRET, 32'hA0 + i, (i == 3) ? 32'd1 : 32'd0);
    icache_read(32'h1C000000);
    drain();

    // uncached dcache read: single beat
    cur_test = "dcache_uncached_rd"; addr_delay = 0;
    rd_data_q.push_back(32'h12345678);
    expect_ev(EV_ADDR, 32'hBFAF8000, 32'h000);
    expect_ev(EV_DACK, 0, 0);
    expect_ev(EV_DRET, 32'h12345678, 32'd1);
    dcache_read(32'hBFAF8000, 1'b1);
    drain();

    // full-line write-back with wready stalled on beat 1; strobe must be forced to F
    cur_test = "writeback_stall"; addr_delay = 1; stall_beat = 1; stall_cycles = 2; bresp_delay = 2;
    expect_ev(EV_WACK, 0, 0);
    expect_ev(EV_ADDR, 32'h00001000, 32'h103);
    expect_ev(EV_WBEAT, 32'h11111111, 32'h1E);
    expect_ev(EV_WSTALL, 32'h22222222, 32'h1E);
    expect_ev(EV_WSTALL, 32'h22222222, 32'h1E);
    expect_ev(EV_WBEAT, 32'h22222222, 32'h1E);
    expect_ev(EV_WBEAT, 32'h33333333, 32'h1E);
    expect_ev(EV_WBEAT, 32'h44444444, 32'h1F);
    expect_ev(EV_WDONE, 0, 32'd1);
    dcache_write(32'h00001000, 1'b0, 4'h0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
    drain();

    // uncached single-word write with partial strobe
    cur_test = "uncached_wr"; addr_delay = 0; stall_beat = -1; bresp_delay = 0;
    expect_ev(EV_WACK, 0, 0);
    expect_ev(EV_ADDR, 32'h00002004, 32'h100);
    expect_ev(EV_WBEAT, 32'hCAFEF00D, 32'h07);
    expect_ev(EV_WDONE, 0, 32'd1);
    dcache_write(32'h00002004, 1'b1, 4'h3, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hCAFEF00D});
    drain();

    // all three requests together from reset: write, dcache read, icache read
    cur_test = "simultaneous";
    do_reset();
    for (int i = 0; i < 4; i++) rd_data_q.push_back(32'h40000000 + i);
    for (int i = 0; i < 4; i++) rd_data_q.push_back(32'h30000000 + i);
    expect_ev(EV_WACK, 0, 0);
    expect_ev(EV_ADDR, 32'h00005000, 32'h100);
    expect_ev(EV_WBEAT, 32'h55AA55AA, 32'h1F);
    expect_ev(EV_WDONE, 0, 32'd1);
    expect_ev(EV_ADDR, 32'h00004000, 32'h003);
    expect_ev(EV_DACK, 0, 0);
    for (int i = 0; i < 4; i++) expect_ev(EV_DRET, 32'h40000000 + i, (i == 3) ? 32'd1 : 32'd0);
    expect_ev(EV_ADDR, 32'h00003000, 32'h003);
    expect_ev(EV_IACK, 0, 0);
    for (int i = 0; i < 4; i++) expect_ev(EV_IRET, 32'h30000000 + i, (i == 3) ? 32'd1 : 32'd0);
    fork
      icache_read(32'h00003000);
      dcache_read(32'h00004000, 1'b0);
      dcache_write(32'h00005000, 1'b1, 4'hF, {96'd0, 32'h55AA55AA});
    join
    drain();

    // back-to-back reads from both sides alternate (last read grant was icache)
    cur_test = "round_robin";
    rd_data_q.push_back(32'h0C000001);
    for (int i = 0; i < 4; i++) rd_data_q.push_back(32'hA1000000 + i);
    rd_data_q.push_back(32'h0D000001);
    for (int i = 0; i < 4; i++) rd_data_q.push_back(32'hB1000000 + i);
    expect_ev(EV_ADDR, 32'h00007000, 32'h000);
    expect_ev(EV_DACK, 0, 0);
    expect_ev(EV_DRET, 32'h0C000001, 32'd1);
    expect_ev(EV_ADDR, 32'h00008000, 32'h003);
    expect_ev(EV_IACK, 0, 0);
    for (int i = 0; i < 4; i++) expect_ev(EV_IRET, 32'hA1000000 + i, (i == 3) ? 32'd1 : 32'd0);
    expect_ev(EV_ADDR, 32'h00007004, 32'h000);
    expect_ev(EV_DACK, 0, 0);
    expect_ev(EV_DRET, 32'h0D000001, 32'd1);
    expect_ev(EV_ADDR, 32'h00008040, 32'h003);
    expect_ev(EV_IACK, 0, 0);
    for (int i = 0; i < 4; i++) expect_ev(EV_IRET, 32'hB1000000 + i, (i == 3) ? 32'd1 : 32'd0);
    fork
      begin dcache_read(32'h00007000, 1'b1); dcache_read(32'h00007004, 1'b1); end
      begin icache_read(32'h00008000); icache_read(32'h00008040); end
    join
    drain();

    // reset during beat 2 of an icache refill: remaining beats must not be forwarded
    cur_test = "rst_mid_burst";
    for (int i = 0; i < 4; i++) rd_data_q.push_back(32'hB0 + i);
    expect_ev(EV_ADDR, 32'h1C000040, 32'h003);
    expect_ev(EV_IACK, 0, 0);
    expect_ev(EV_IRET, 32'hB0, 32'd0);
    expect_ev(EV_IRET, 32'hB1, 32'd0);
    icache_read(32'h1C000040);
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_during_beat2");
    step();
    rst = 1'b0;
    @(negedge clk);
    check_zero("after_rst_beat3_ignored");
    repeat (3) step();
    drain();

    // fresh request after the aborted burst
    cur_test = "after_rst_read";
    for (int i = 0; i < 4; i++) rd_data_q.push_back(32'hC0 + i);
    expect_ev(EV_ADDR, 32'h00006000, 32'h003);
    expect_ev(EV_DACK, 0, 0);
    for (int i = 0; i < 4; i++) expect_ev(EV_DRET, 32'hC0 + i, (i == 3) ? 32'd1 : 32'd0);
    dcache_read(32'h00006000, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
